// File: rtl/qspi_read_arbiter.sv
`default_nettype none
// ============================================================================
// qspi_read_arbiter : round-robin fetch/load arbiter sequencing qspi_core reads
// Revision 1.0
// ============================================================================
module qspi_read_arbiter #(
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter int         ADDR_BITS = 24,
  parameter int         RD_BITS   = 32,
  parameter int         DUMMY_CYC = 0,
  parameter bit         LSB_FIRST = 1'b0,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [23:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic [23:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        core_we_o,
  output logic        core_re_o,
  output logic [3:0]  core_be_o,
  output logic [23:0] core_addr_o,
  output logic [31:0] core_wdata_o,
  input  logic [31:0] core_rdata_i,
  input  logic        core_intr_rx_i,
  output logic        busy_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  localparam logic [31:0] c_start_word =
      (32'(ADDR_BITS) & 32'h3F)
    | ((32'(RD_BITS) & 32'h3F) << 6)
    | 32'h0000_8000
    | (32'(LSB_FIRST) << 17)
    | ((32'(DUMMY_CYC) & 32'h1F) << 18)
    | 32'h0080_0000;
  // Forces the core back to idle and clears its stop latch.
  localparam logic [31:0] c_clr_word = 32'h0100_8000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CTRL = 3'd3,
    S_WAIT = 3'd4,
    S_CLR  = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_last_d;
  logic              r_port_d;
  logic [23:0]       r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_core_we;
  logic [23:0]       r_core_addr;
  logic [31:0]       r_core_wdata;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_i_err;
  logic              r_d_err;

  logic w_any;
  logic w_pick_d;
  logic w_arb;
  logic w_done;

  assign w_any    = i_req_i | d_req_i;
  // d wins when it is alone, or when both wait and i was served last.
  assign w_pick_d = d_req_i & (~i_req_i | ~r_last_d);
  assign w_arb    = (r_state == S_IDLE) & ~rst_i;
  assign w_done   = core_intr_rx_i | (r_cnt == c_cnt_last);

  assign i_gnt_o      = w_arb & w_any & ~w_pick_d;
  assign d_gnt_o      = w_arb & w_pick_d;
  assign i_rvalid_o   = r_i_rvalid;
  assign d_rvalid_o   = r_d_rvalid;
  assign i_rdata_o    = r_i_rdata;
  assign d_rdata_o    = r_d_rdata;
  assign i_err_o      = r_i_err;
  assign d_err_o      = r_d_err;
  assign core_we_o    = r_core_we;
  assign core_re_o    = 1'b0;
  assign core_be_o    = 4'hF;
  assign core_addr_o  = r_core_addr;
  assign core_wdata_o = r_core_wdata;
  assign busy_o       = (r_state != S_IDLE);

  // Bus outputs are loaded on entry to a state, so each state's write is visible during it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last_d     <= 1'b1;
      r_port_d     <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_core_we    <= 1'b0;
      r_core_addr  <= '0;
      r_core_wdata <= '0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_err      <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      r_core_we    <= 1'b0;
      r_core_addr  <= '0;
      r_core_wdata <= '0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_port_d     <= w_pick_d;
            r_last_d     <= w_pick_d;
            r_addr       <= w_pick_d ? d_addr_i : i_addr_i;
            r_core_we    <= 1'b1;
            r_core_addr  <= 24'd4;
            r_core_wdata <= {24'h0, READ_CMD};
            r_state      <= S_CMD;
          end
        end
        S_CMD: begin
          r_core_we    <= 1'b1;
          r_core_addr  <= 24'd8;
          r_core_wdata <= {8'h00, r_addr};
          r_state      <= S_DATA;
        end
        S_DATA: begin
          r_core_we    <= 1'b1;
          r_core_addr  <= 24'd0;
          r_core_wdata <= c_start_word;
          r_state      <= S_CTRL;
        end
        S_CTRL: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            r_core_we    <= 1'b1;
            r_core_wdata <= c_clr_word;
            r_state      <= S_CLR;
            // The receive pulse takes priority over a coincident timeout.
            if (r_port_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= core_intr_rx_i ? core_rdata_i : 32'h0;
              r_d_err    <= ~core_intr_rx_i;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= core_intr_rx_i ? core_rdata_i : 32'h0;
              r_i_err    <= ~core_intr_rx_i;
            end
          end
        end
        S_CLR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_read_arbiter.sv
`default_nettype none
// Bench for qspi_read_arbiter: a cycle-level model predicts grants, core writes and responses.
module tb_qspi_read_arbiter;

  localparam int          TB_TO   = 16;
  localparam logic [31:0] START_W = 32'h0000_8000 | 32'd24 | (32'd32 << 6) | (32'd1 << 23);
  localparam logic [31:0] CLR_W   = 32'h0100_8000;
  localparam int          NEVER   = 1 << 30;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_req_i = 1'b0;
  logic [23:0] i_addr_i = '0;
  logic        d_req_i = 1'b0;
  logic [23:0] d_addr_i = '0;
  logic [31:0] core_rdata_i;
  logic        core_intr_rx_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] i_rdata_o, d_rdata_o;
  logic        core_we_o, core_re_o, busy_o;
  logic [3:0]  core_be_o;
  logic [23:0] core_addr_o;
  logic [31:0] core_wdata_o;

  qspi_read_arbiter #(.TIMEOUT(TB_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .core_we_o(core_we_o), .core_re_o(core_re_o), .core_be_o(core_be_o),
    .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_rdata_i(core_rdata_i), .core_intr_rx_i(core_intr_rx_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [23:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic port_d; logic [31:0] data; logic err; int cyc; } rsp_t;
  wr_t  wq[$];
  rsp_t rq[$];

  int n_chk = 0;
  int n_fail = 0;

  // Model state, owned by the monitor process
  logic        last_d = 1'b1;
  int          idle_from = 0;
  int          gnt_cyc = -1;
  int          intr_cyc = -1;
  int          spur_cyc = -1;
  logic [31:0] plan_data = '0;
  logic [31:0] held_i_data = '0, held_d_data = '0;
  logic        held_i_err = 1'b0, held_d_err = 1'b0;
  int          rst_seen = 0;
  logic [1:0]  exp_g, exp_rv;
  logic        port;
  int          c, resp, mode, j, rsel;
  logic [31:0] pdata;

  // Test controls, owned by the main process
  logic        use_fix = 1'b0;
  int          fix_mode = 0;
  int          fix_delay = 0;
  logic [31:0] fix_data = '0;
  logic        spur_on_cmd = 1'b0;
  int          spur_cyc2 = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void push_wr(logic [23:0] a, logic [31:0] d, int cy);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = cy;
    wq.push_back(w);
  endfunction

  function automatic void push_rsp(logic p, logic [31:0] d, logic e, int cy);
    rsp_t r;
    r.port_d = p; r.data = d; r.err = e; r.cyc = cy;
    rq.push_back(r);
  endfunction

  // Core stand-in: pulses intr_rx on planned/spurious cycles, random rdata otherwise
  initial begin
    core_intr_rx_i = 1'b0;
    core_rdata_i   = '0;
    forever begin
      @(posedge clk_i); #1;
      core_intr_rx_i = (cyc == intr_cyc) || (cyc == spur_cyc) || (cyc == spur_cyc2);
      core_rdata_i   = (cyc == intr_cyc) ? plan_data : $urandom;
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      if (rst_seen > 0) begin
        chk("rst_ctrl", 64'({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, i_err_o, d_err_o,
                             busy_o, core_we_o, core_re_o, core_be_o}), 64'({9'b0, 4'hF}));
        chk("rst_bus", 64'({core_addr_o, core_wdata_o}), 64'(0));
        chk("rst_rdata", {i_rdata_o, d_rdata_o}, 64'(0));
      end
      rst_seen++;
      wq.delete(); rq.delete();
      intr_cyc = -1; spur_cyc = -1; last_d = 1'b1; idle_from = 0; gnt_cyc = -1;
      held_i_data = '0; held_d_data = '0; held_i_err = 1'b0; held_d_err = 1'b0;
    end else begin
      rst_seen = 0;
      chk("busy", 64'(busy_o), 64'((cyc > gnt_cyc) && (cyc < idle_from)));

      exp_g = 2'b00;
      if (cyc >= idle_from) begin
        if (i_req_i && d_req_i) exp_g = last_d ? 2'b10 : 2'b01;
        else if (i_req_i)       exp_g = 2'b10;
        else if (d_req_i)       exp_g = 2'b01;
      end
      chk("gnt", 64'({i_gnt_o, d_gnt_o}), 64'(exp_g));

      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        chk("core_write", 64'({core_we_o, core_re_o, core_be_o, core_addr_o, core_wdata_o}),
            64'({1'b1, 1'b0, 4'hF, wq[0].addr, wq[0].data}));
        void'(wq.pop_front());
      end else begin
        chk("core_quiet", 64'({core_we_o, core_re_o, core_be_o}), 64'({2'b00, 4'hF}));
      end

      exp_rv = 2'b00;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        exp_rv = rq[0].port_d ? 2'b01 : 2'b10;
        if (rq[0].port_d) begin held_d_data = rq[0].data; held_d_err = rq[0].err; end
        else begin held_i_data = rq[0].data; held_i_err = rq[0].err; end
        void'(rq.pop_front());
      end
      chk("rvalid", 64'({i_rvalid_o, d_rvalid_o}), 64'(exp_rv));
      chk("i_resp", 64'({i_err_o, i_rdata_o}), 64'({held_i_err, held_i_data}));
      chk("d_resp", 64'({d_err_o, d_rdata_o}), 64'({held_d_err, held_d_data}));

      if (exp_g != 2'b00) begin
        port    = exp_g[0];
        last_d  = port;
        gnt_cyc = cyc;
        c       = cyc + 3;
        push_wr(24'd4, 32'h0000_0003, cyc + 1);
        push_wr(24'd8, {8'h00, (port ? d_addr_i : i_addr_i)}, cyc + 2);
        push_wr(24'd0, START_W, cyc + 3);
        if (spur_on_cmd) spur_cyc = cyc + 1;
        if (use_fix) begin
          mode = fix_mode; j = fix_delay; pdata = fix_data;
        end else begin
          rsel  = $urandom_range(3, 0);
          mode  = (rsel < 2) ? 0 : rsel - 1;
          j     = $urandom_range(TB_TO - 2, 0);
          pdata = $urandom;
        end
        case (mode)
          0: begin
            intr_cyc = c + 1 + j; resp = c + 2 + j; plan_data = pdata;
            push_rsp(port, pdata, 1'b0, resp);
          end
          1: begin
            intr_cyc = -1; resp = c + 1 + TB_TO;
            push_rsp(port, 32'h0, 1'b1, resp);
          end
          2: begin
            intr_cyc = c + TB_TO; resp = c + 1 + TB_TO; plan_data = pdata;
            push_rsp(port, pdata, 1'b0, resp);
          end
          default: begin
            intr_cyc = -1; resp = NEVER;
          end
        endcase
        if (mode < 3) begin
          push_wr(24'd0, CLR_W, resp);
          idle_from = resp + 1;
        end else begin
          idle_from = NEVER;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic serve(input int ni, input int nd);
    logic gi, gd;
    int   n;
    int   ci, cd;
    ci = ni; cd = nd; n = 0;
    i_req_i = (ci > 0);
    d_req_i = (cd > 0);
    while ((i_req_i || d_req_i) && n < 400) begin
      @(negedge clk_i);
      gi = i_gnt_o; gd = d_gnt_o;
      tick();
      if (gi) begin ci--; i_addr_i = 24'($urandom); if (ci <= 0) i_req_i = 1'b0; end
      if (gd) begin cd--; d_addr_i = 24'($urandom); if (cd <= 0) d_req_i = 1'b0; end
      n++;
    end
    chk("serve_bound", 64'(i_req_i || d_req_i), 64'(0));
    i_req_i = 1'b0;
    d_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int   n;
    logic pending;
    n = 0; pending = 1'b1;
    while (pending && n < 400) begin
      @(negedge clk_i);
      pending = (cyc < idle_from) || (rq.size() != 0) || (wq.size() != 0);
      tick();
      n++;
    end
    chk("idle_bound", 64'(pending), 64'(0));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  int pat, ni, nd;

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;

    use_fix = 1'b1; fix_mode = 0; fix_delay = 3; fix_data = 32'hDEAD_BEEF;
    i_addr_i = 24'h001234;
    serve(1, 0);
    wait_idle();

    do_reset();
    use_fix = 1'b0;
    i_addr_i = 24'($urandom); d_addr_i = 24'($urandom);
    serve(2, 2);
    wait_idle();

    use_fix = 1'b1; fix_mode = 1;
    serve(0, 1);
    wait_idle();

    fix_mode = 2; fix_data = 32'h1234_5678;
    serve(1, 0);
    wait_idle();

    spur_cyc2 = cyc + 2;
    repeat (4) tick();
    spur_on_cmd = 1'b1; fix_mode = 0; fix_delay = 5; fix_data = $urandom;
    serve(0, 1);
    wait_idle();
    spur_on_cmd = 1'b0;

    fix_mode = 3;
    serve(1, 0);
    repeat (6) tick();
    do_reset();
    fix_mode = 0; fix_delay = 0; fix_data = $urandom;
    serve(1, 0);
    wait_idle();

    use_fix = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pat = $urandom_range(3, 1);
      ni  = pat[0] ? $urandom_range(2, 1) : 0;
      nd  = pat[1] ? $urandom_range(2, 1) : 0;
      i_addr_i = 24'($urandom);
      d_addr_i = 24'($urandom);
      serve(ni, nd);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
